// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ctrl_pkg : shared types and encodings for the ALU execute sequencer    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_MD_WAIT = 3'd2,
    ST_WB      = 3'd3,
    ST_EXC     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_ALU_OVF = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_MD      = 3'd3,
    CLS_ILLEGAL = 3'd4
  } cls_t;

  localparam logic [2:0] c_ALU_LOAD_A = 3'b000;
  localparam logic [2:0] c_ALU_ADD    = 3'b001;
  localparam logic [2:0] c_ALU_SUB    = 3'b010;
  localparam logic [2:0] c_ALU_AND    = 3'b011;
  localparam logic [2:0] c_ALU_INC    = 3'b100;
  localparam logic [2:0] c_ALU_NOT    = 3'b101;
  localparam logic [2:0] c_ALU_XOR    = 3'b110;
  localparam logic [2:0] c_ALU_CMP    = 3'b111;

  localparam logic [1:0] c_SRC_REG_B    = 2'b00;
  localparam logic [1:0] c_SRC_SEXT_IMM = 2'b01;
  localparam logic [1:0] c_SRC_IMM_SHL2 = 2'b10;
  localparam logic [1:0] c_SRC_CONST4   = 2'b11;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;

  localparam logic [5:0] c_FN_MULT = 6'h18;
  localparam logic [5:0] c_FN_DIV  = 6'h1A;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;

  localparam logic [1:0] c_EXC_OVF     = 2'b00;
  localparam logic [1:0] c_EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] c_EXC_DIV0    = 2'b10;
  localparam logic [1:0] c_EXC_TIMEOUT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_sequencer_if : instruction / ALU control / mult-div handshake bus   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface alu_op_sequencer_if;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       zero;
  logic       md_done;
  logic       md_div0;
  logic [2:0] alu_op;
  logic [1:0] alu_src_sel;
  logic       md_start;
  logic       md_is_div;
  logic       reg_write;
  logic       hilo_write;
  logic       branch_taken;
  logic       busy;
  logic       done;
  logic       exc;
  logic [1:0] exc_code;

  modport slave (
    input  start, opcode, funct, overflow, zero, md_done, md_div0,
    output alu_op, alu_src_sel, md_start, md_is_div, reg_write, hilo_write,
           branch_taken, busy, done, exc, exc_code
  );

  modport master (
    output start, opcode, funct, overflow, zero, md_done, md_div0,
    input  alu_op, alu_src_sel, md_start, md_is_div, reg_write, hilo_write,
           branch_taken, busy, done, exc, exc_code
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_decode : combinational opcode/funct -> class, ALU op, B-source      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  wire logic [5:0] i_opcode,
  input  wire logic [5:0] i_funct,
  output cls_t            o_cls,
  output logic [2:0]      o_alu_op,
  output logic [1:0]      o_alu_src_sel
);

  always_comb begin
    o_cls         = CLS_ILLEGAL;
    o_alu_op      = c_ALU_LOAD_A;
    o_alu_src_sel = c_SRC_REG_B;
    case (i_opcode)
      c_OP_RTYPE: begin
        case (i_funct)
          c_FN_ADD:  begin o_cls = CLS_ALU_OVF; o_alu_op = c_ALU_ADD; end
          c_FN_SUB:  begin o_cls = CLS_ALU_OVF; o_alu_op = c_ALU_SUB; end
          c_FN_AND:  begin o_cls = CLS_ALU;     o_alu_op = c_ALU_AND; end
          c_FN_XOR:  begin o_cls = CLS_ALU;     o_alu_op = c_ALU_XOR; end
          c_FN_SLT:  begin o_cls = CLS_ALU;     o_alu_op = c_ALU_CMP; end
          c_FN_MULT,
          c_FN_DIV:  o_cls = CLS_MD;
          default:   o_cls = CLS_ILLEGAL;
        endcase
      end
      c_OP_ADDI: begin
        o_cls         = CLS_ALU_OVF;
        o_alu_op      = c_ALU_ADD;
        o_alu_src_sel = c_SRC_SEXT_IMM;
      end
      c_OP_ADDIU: begin
        o_cls         = CLS_ALU;
        o_alu_op      = c_ALU_ADD;
        o_alu_src_sel = c_SRC_SEXT_IMM;
      end
      c_OP_BEQ,
      c_OP_BNE: begin
        o_cls    = CLS_BRANCH;
        o_alu_op = c_ALU_SUB;
      end
      default: o_cls = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_sequencer : multicycle ALU execute / mult-div sequencing FSM        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40
) (
  input  wire logic            clk,
  input  wire logic            reset,
  alu_op_sequencer_if.slave    bus
);

  localparam int                 c_CNT_W     = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(MD_MAX_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_opcode;
  logic [5:0]         r_funct;
  logic [c_CNT_W-1:0] r_md_cnt;
  logic [c_CNT_W-1:0] w_md_cnt_inc;
  logic [1:0]         r_exc_code;
  logic [1:0]         w_exc_code_nxt;
  logic               r_branch_taken;
  cls_t               w_cls;
  logic [2:0]         w_alu_op;
  logic [1:0]         w_alu_src_sel;
  logic               w_is_div;

  alu_op_decode u_decode (
    .i_opcode      (r_opcode),
    .i_funct       (r_funct),
    .o_cls         (w_cls),
    .o_alu_op      (w_alu_op),
    .o_alu_src_sel (w_alu_src_sel)
  );

  assign w_md_cnt_inc = r_md_cnt + c_CNT_ONE;
  assign w_is_div     = (w_cls == CLS_MD) && (r_funct == c_FN_DIV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Instruction latch, MD_WAIT counter and registered exception/branch outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opcode       <= '0;
      r_funct        <= '0;
      r_md_cnt       <= '0;
      r_exc_code     <= '0;
      r_branch_taken <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.start) begin
        r_opcode <= bus.opcode;
        r_funct  <= bus.funct;
      end
      if (r_state == ST_EXEC)         r_md_cnt <= '0;
      else if (r_state == ST_MD_WAIT) r_md_cnt <= w_md_cnt_inc;
      if (w_state_nxt == ST_EXC) r_exc_code <= w_exc_code_nxt;
      if (r_state == ST_EXEC)
        r_branch_taken <= (w_cls == CLS_BRANCH) &&
                          ((r_opcode == c_OP_BEQ) ? bus.zero : !bus.zero);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_exc_code_nxt = r_exc_code;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_cls == CLS_ILLEGAL) begin
          w_state_nxt    = ST_EXC;
          w_exc_code_nxt = c_EXC_ILLEGAL;
        end else if (w_cls == CLS_MD) begin
          w_state_nxt = ST_MD_WAIT;
        end else if (w_cls == CLS_ALU_OVF && bus.overflow) begin
          w_state_nxt    = ST_EXC;
          w_exc_code_nxt = c_EXC_OVF;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      // A completion arriving on the limit cycle takes priority over timeout.
      ST_MD_WAIT: begin
        if (bus.md_done) begin
          if (bus.md_div0) begin
            w_state_nxt    = ST_EXC;
            w_exc_code_nxt = c_EXC_DIV0;
          end else begin
            w_state_nxt = ST_WB;
          end
        end else if (w_md_cnt_inc == c_CNT_LIMIT) begin
          w_state_nxt    = ST_EXC;
          w_exc_code_nxt = c_EXC_TIMEOUT;
        end
      end
      ST_WB:   w_state_nxt = ST_IDLE;
      ST_EXC:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.alu_op       = c_ALU_LOAD_A;
    bus.alu_src_sel  = c_SRC_REG_B;
    bus.md_start     = 1'b0;
    bus.md_is_div    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.hilo_write   = 1'b0;
    bus.branch_taken = 1'b0;
    bus.busy         = (r_state != ST_IDLE);
    bus.done         = 1'b0;
    bus.exc          = 1'b0;
    bus.exc_code     = 2'b00;
    case (r_state)
      ST_EXEC: begin
        bus.alu_op      = w_alu_op;
        bus.alu_src_sel = w_alu_src_sel;
        bus.md_start    = (w_cls == CLS_MD);
        bus.md_is_div   = w_is_div;
      end
      ST_MD_WAIT: begin
        bus.alu_op      = w_alu_op;
        bus.alu_src_sel = w_alu_src_sel;
        bus.md_is_div   = w_is_div;
      end
      ST_WB: begin
        bus.done         = 1'b1;
        bus.reg_write    = (w_cls == CLS_ALU) || (w_cls == CLS_ALU_OVF);
        bus.hilo_write   = (w_cls == CLS_MD);
        bus.md_is_div    = w_is_div;
        bus.branch_taken = r_branch_taken;
      end
      ST_EXC: begin
        bus.exc      = 1'b1;
        bus.exc_code = r_exc_code;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_op_sequencer : directed bench with result scoreboard                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;
  import alu_ctrl_pkg::*;

  typedef struct packed {
    logic       is_exc;
    logic [1:0] code;
    logic       rw;
    logic       hw;
    logic       bt;
    logic       dv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.MD_MAX_CYCLES(40)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic x, input logic [1:0] c, input logic rw,
                              input logic hw, input logic bt, input logic dv);
    return {x, c, rw, hw, bt, dv};
  endfunction

  function automatic logic [15:0] outs();
    return {1'b0, bus.alu_op, bus.alu_src_sel, bus.md_start, bus.md_is_div,
            bus.reg_write, bus.hilo_write, bus.branch_taken, bus.busy,
            bus.done, bus.exc, bus.exc_code};
  endfunction

  // Leaves the bench in the EXEC cycle of the issued instruction.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input exp_t e,
                       input logic push);
    bus.opcode = op;
    bus.funct  = fn;
    bus.start  = 1'b1;
    if (push) sb.push_back(e);
    step();
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin : p_mon
    exp_t e_exp;
    exp_t e_obs;
    if (reset === 1'b1 && (bus.done === 1'b1 || bus.exc === 1'b1)) begin
      chk("done_exc_excl", 16'(bus.done & bus.exc), 16'(1'b0));
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $error("FAIL sb_unexpected: observed done=%0b exc=%0b, expected no result",
               bus.done, bus.exc);
      end else begin
        e_exp = sb.pop_front();
        e_obs = {bus.exc, bus.exc_code, bus.reg_write, bus.hilo_write,
                 bus.branch_taken, bus.md_is_div};
        n_checks--;
        chk("sb_result", 16'(e_obs), 16'(e_exp));
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.opcode   = '0;
    bus.funct    = '0;
    bus.overflow = 1'b0;
    bus.zero     = 1'b0;
    bus.md_done  = 1'b0;
    bus.md_div0  = 1'b0;
    #12;
    chk("reset_outputs", outs(), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // add: EXEC then WB then IDLE
    issue(c_OP_RTYPE, c_FN_ADD, mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    chk("add_exec_aluop", 16'(bus.alu_op), 16'(c_ALU_ADD));
    chk("add_exec_src", 16'(bus.alu_src_sel), 16'(c_SRC_REG_B));
    step();
    chk("add_wb", 16'({bus.done, bus.reg_write}), 16'(2'b11));
    step();
    chk("add_idle_busy", 16'(bus.busy), 16'(1'b0));

    // addi with overflow -> exception 00
    issue(c_OP_ADDI, 6'h00, mk(1'b1, c_EXC_OVF, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    chk("addi_exec", 16'({bus.alu_op, bus.alu_src_sel}), 16'({c_ALU_ADD, c_SRC_SEXT_IMM}));
    bus.overflow = 1'b1;
    step();
    bus.overflow = 1'b0;
    chk("addi_ovf_exc", 16'({bus.exc, bus.exc_code, bus.reg_write, bus.done}),
        16'({1'b1, c_EXC_OVF, 1'b0, 1'b0}));
    step();

    // addiu ignores overflow
    issue(c_OP_ADDIU, 6'h00, mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    bus.overflow = 1'b1;
    step();
    bus.overflow = 1'b0;
    chk("addiu_wb", 16'({bus.done, bus.reg_write, bus.exc}), 16'(3'b110));
    step();

    // beq / bne with zero=1
    issue(c_OP_BEQ, 6'h00, mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    chk("beq_exec_aluop", 16'(bus.alu_op), 16'(c_ALU_SUB));
    bus.zero = 1'b1;
    step();
    bus.zero = 1'b0;
    chk("beq_wb", 16'({bus.done, bus.branch_taken, bus.reg_write}), 16'(3'b110));
    step();
    issue(c_OP_BNE, 6'h00, mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    bus.zero = 1'b1;
    step();
    bus.zero = 1'b0;
    chk("bne_wb", 16'({bus.done, bus.branch_taken}), 16'(2'b10));
    step();

    // div, md_done 5 cycles after md_start
    issue(c_OP_RTYPE, c_FN_DIV, mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    chk("div_exec", 16'({bus.md_start, bus.md_is_div}), 16'(2'b11));
    step(4);
    chk("div_wait", 16'({bus.md_start, bus.busy, bus.done, bus.md_is_div}), 16'(4'b0101));
    step();
    bus.md_done = 1'b1;
    step();
    bus.md_done = 1'b0;
    chk("div_wb", 16'({bus.done, bus.hilo_write, bus.md_is_div, bus.reg_write}), 16'(4'b1110));
    step();

    // div by zero
    issue(c_OP_RTYPE, c_FN_DIV, mk(1'b1, c_EXC_DIV0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    step(5);
    bus.md_done = 1'b1;
    bus.md_div0 = 1'b1;
    step();
    bus.md_done = 1'b0;
    bus.md_div0 = 1'b0;
    chk("div0_exc", 16'({bus.exc, bus.exc_code, bus.hilo_write}), 16'({1'b1, c_EXC_DIV0, 1'b0}));
    step();

    // mult timeout after 40 cycles in MD_WAIT
    issue(c_OP_RTYPE, c_FN_MULT, mk(1'b1, c_EXC_TIMEOUT, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    chk("mult_exec", 16'({bus.md_start, bus.md_is_div}), 16'(2'b10));
    step(40);
    chk("mult_last_wait", 16'({bus.busy, bus.exc}), 16'(2'b10));
    step();
    chk("mult_timeout", 16'({bus.exc, bus.exc_code}), 16'({1'b1, c_EXC_TIMEOUT}));
    step();

    // md_done on the limit cycle beats the timeout
    issue(c_OP_RTYPE, c_FN_MULT, mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    step(40);
    bus.md_done = 1'b1;
    step();
    bus.md_done = 1'b0;
    chk("mult_edge_wb", 16'({bus.done, bus.hilo_write, bus.exc}), 16'(3'b110));
    step();

    // illegal opcode
    issue(6'h3F, 6'h00, mk(1'b1, c_EXC_ILLEGAL, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    step();
    chk("illegal_exc", 16'({bus.exc, bus.exc_code}), 16'({1'b1, c_EXC_ILLEGAL}));
    step();

    // asynchronous reset in the middle of MD_WAIT
    issue(c_OP_RTYPE, c_FN_DIV, mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    step(2);
    chk("pre_reset_busy", 16'(bus.busy), 16'(1'b1));
    #2 reset = 1'b0;
    #1;
    chk("reset_mid_md", outs(), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // start held high through WB is not taken again
    bus.opcode = c_OP_RTYPE;
    bus.funct  = c_FN_AND;
    bus.start  = 1'b1;
    sb.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    chk("and_exec_aluop", 16'(bus.alu_op), 16'(c_ALU_AND));
    step();
    chk("and_wb", 16'({bus.done, bus.reg_write}), 16'(2'b11));
    step();
    bus.start = 1'b0;
    chk("held_start_idle", 16'({bus.busy, bus.done}), 16'(2'b00));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_second_done", 16'({bus.busy, bus.done}), 16'(2'b00));
    end

    chk("sb_empty", 16'(sb.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multicycle controller for the ALU execute path of the MIPS datapath. It takes one decoded instruction at a time and sequences the ALU through execute and write-back. Per state it drives the 3-bit ALU operation code and the 2-bit ALU source-mux selector. It also hands mult/div off to the separate multiply/divide unit, waits for completion and reports overflow, illegal-instruction, divide-by-zero and timeout exceptions.

## Interface
Parameters:
- MD_MAX_CYCLES, 40: maximum cycles spent in MD_WAIT before a timeout exception.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  instruction valid. Sampled only in IDLE.
- opcode  in  6  instruction [31:26]. Latched with start.
- funct  in  6  instruction [5:0]. Latched with start.
- overflow  in  1  ALU overflow flag. Sampled at the end of EXEC.
- zero  in  1  ALU zero flag. Sampled at the end of EXEC.
- md_done  in  1  mult/div unit finished (1-cycle pulse).
- md_div0  in  1  mult/div unit divisor-zero flag. Valid with md_done.
- alu_op  out  3  ALU code:
  - 000 load A, 001 add, 010 sub, 011 and
  - 100 inc, 101 not, 110 xor, 111 compare
- alu_src_sel  out  2  ALU B-input mux:
  - 00 reg B, 01 sign-ext imm, 10 imm<<2, 11 constant 4
- md_start  out  1  1-cycle pulse launching mult/div.
- md_is_div  out  1  1 = divide, 0 = multiply. Held while the mult/div operation is active.
- reg_write  out  1  register-file write enable.
- hilo_write  out  1  HI/LO write enable.
- branch_taken  out  1  beq/bne outcome.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle completion pulse.
- exc  out  1  1-cycle exception pulse.
- exc_code  out  2  exception cause:
  - 00 overflow, 01 illegal, 10 div-by-zero, 11 md timeout

## Operation
States are IDLE, EXEC, MD_WAIT, WB and EXC.

Decode (R-type when opcode = 0x00):
- add 0x20 → 001 reg B, overflow checked.
- sub 0x22 → 010 reg B, overflow checked.
- and 0x24 → 011 reg B.
- xor 0x26 → 110 reg B.
- slt 0x2A → 111 reg B.
- mult 0x18, div 0x1A → MD class.

Decode (I-type):
- addi 0x08 → 001 sign-ext, overflow checked.
- addiu 0x09 → 001 sign-ext, no overflow check.
- beq 0x04, bne 0x05 → 010 reg B, branch class.
- Any other opcode/funct → illegal.

Transitions:
- IDLE → EXEC on start. Opcode/funct are latched into internal registers.
- EXEC:
  - illegal instruction → EXC, code 01.
  - MD class: md_start pulses this cycle → MD_WAIT.
  - overflow-checked op with overflow=1 → EXC, code 00.
  - otherwise → WB.
- MD_WAIT: cycle counter increments each cycle.
  - md_done & md_div0 → EXC, code 10.
  - md_done → WB.
  - counter reaches MD_MAX_CYCLES without md_done → EXC, code 11.
- WB → IDLE. Asserts done.
  - reg_write=1 for ALU classes.
  - hilo_write=1 for MD.
  - branch_taken registered at the end of EXEC: zero for beq, !zero for bne.
- EXC → IDLE. Asserts exc with exc_code. No write enables.

Rules:
- start outside IDLE is ignored. There is no queuing.
- In IDLE and EXC, alu_op=000 and alu_src_sel=00.
- In MD_WAIT, alu_op and alu_src_sel hold their EXEC values.

## Timing
- Reset asserted (any time, including mid-operation): state=IDLE, counter=0, all outputs 0, branch_taken=0. Reset takes effect immediately, without waiting for clk.
- Outputs are Moore: a function of state plus latched instruction. No combinational path from inputs to outputs.
- ALU instruction: start sampled at edge k → EXEC during cycle k+1 → WB (done) cycle k+2 → IDLE cycle k+3. Latency is 2 cycles; throughput is one instruction per 3 cycles.
- MD instruction: md_start in cycle k+1. If md_done first appears N cycles after md_start, WB occurs on the cycle after the one in which md_done is sampled.
- Timeout: EXC is entered when MD_MAX_CYCLES cycles have elapsed in MD_WAIT with no md_done.
- md_done in the same cycle the counter hits its limit: md_done wins.
- md_done outside MD_WAIT is ignored.
- done and exc are never asserted together.

## Structure
- Package alu_ctrl_pkg holds:
  - the state enum;
  - ALU op codes;
  - alu_src_sel codes;
  - opcode/funct constants;
  - exc_code values;
  - the instruction-class enum (ALU, ALU_OVF, BRANCH, MD, ILLEGAL).
- Sub-module alu_op_decode: purely combinational; maps latched opcode/funct to class, alu_op and alu_src_sel.
- The FSM, the MD_WAIT counter (clog2(MD_MAX_CYCLES+1) bits) and the output registers live in the top module.

## Test plan
- add, opcode 0x00 funct 0x20, start at cycle 0, overflow=0:
  - alu_op=001 and alu_src_sel=00 in cycle 1;
  - reg_write=1 and done=1 in cycle 2;
  - busy=0 in cycle 3.
- addi with overflow=1 in EXEC → exc=1, exc_code=00 in cycle 2; reg_write stays 0.
- beq with zero=1 → alu_op=010 in EXEC; branch_taken=1 and done=1 in WB. Repeat with bne and zero=1 → branch_taken=0.
- div with md_done 5 cycles after md_start → md_is_div=1, hilo_write=1 in WB. Repeat with md_div0=1 → exc_code=10.
- mult with md_done never asserted and MD_MAX_CYCLES=40 → exc_code=11 after 40 cycles in MD_WAIT. Then opcode 0x3F → exc_code=01.
- reset driven low during MD_WAIT → all outputs 0 immediately. A start held high during WB is ignored and no second done appears.
